// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: expands one load/store-multiple instruction into a stream of
// single-register micro-ops, lowest register first, while holding fetch.
module lmsm_sequencer #(
    parameter int MASK_W = 8,
    localparam int IDX_W = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_sm_in,
    input  logic [MASK_W-1:0] mask_in,
    input  logic              hold,
    input  logic              flush,
    output logic              busy,
    output logic              stall_if,
    output logic              uop_valid,
    output logic              uop_is_store,
    output logic [IDX_W-1:0]  uop_reg,
    output logic [IDX_W-1:0]  uop_offset,
    output logic              uop_last,
    output logic              done
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    logic [MASK_W-1:0] mask_rem;
    logic [IDX_W-1:0]  cnt;
    logic              is_sm;
    logic [IDX_W-1:0]  low_idx;
    logic              one_left;

    // Descending scan so the last hit wins, leaving the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask_rem[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_left = (mask_rem != '0) && ((mask_rem & (mask_rem - MASK_W'(1))) == '0);

    assign busy         = (state == ISSUE);
    assign uop_valid    = busy;
    assign uop_is_store = busy & is_sm;
    assign uop_reg      = busy ? low_idx : '0;
    assign uop_offset   = busy ? cnt : '0;
    assign uop_last     = busy & one_left;

    // Flush always releases fetch so the redirected stream is not blocked.
    always_comb begin
        stall_if = 1'b0;
        if (!flush) begin
            if (state == IDLE) begin
                stall_if = start && (mask_in != '0);
            end else begin
                stall_if = !one_left || hold;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mask_rem <= '0;
            cnt      <= '0;
            is_sm    <= 1'b0;
            done     <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            mask_rem <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mask_in != '0) begin
                            mask_rem <= mask_in;
                            is_sm    <= is_sm_in;
                            cnt      <= '0;
                            state    <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        mask_rem <= mask_rem & (mask_rem - MASK_W'(1));
                        if (one_left) begin
                            cnt   <= '0;
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: inputs change on the falling edge and
// outputs are compared 1ns later, well clear of the rising edge.
module tb_lmsm_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, is_sm_in, hold, flush;
    logic [7:0] mask_in;
    logic       busy, stall_if, uop_valid, uop_is_store, uop_last, done;
    logic [2:0] uop_reg, uop_offset;

    int checks   = 0;
    int failures = 0;

    lmsm_sequencer #(.MASK_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_sm_in     (is_sm_in),
        .mask_in      (mask_in),
        .hold         (hold),
        .flush        (flush),
        .busy         (busy),
        .stall_if     (stall_if),
        .uop_valid    (uop_valid),
        .uop_is_store (uop_is_store),
        .uop_reg      (uop_reg),
        .uop_offset   (uop_offset),
        .uop_last     (uop_last),
        .done         (done)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive on the falling edge, settle 1ns.
    task automatic applyStimulus(input logic s, input logic sm, input logic [7:0] m,
                                 input logic h, input logic f, input logic r);
        @(negedge clk);
        start    = s;
        is_sm_in = sm;
        mask_in  = m;
        hold     = h;
        flush    = f;
        reset    = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic e_busy, input logic e_stall,
                               input logic e_valid, input logic e_store, input logic [2:0] e_reg,
                               input logic [2:0] e_off, input logic e_last, input logic e_done);
        logic [11:0] obs, exp;
        obs = {busy, stall_if, uop_valid, uop_is_store, uop_reg, uop_offset, uop_last, done};
        exp = {e_busy, e_stall, e_valid, e_store, e_reg, e_off, e_last, e_done};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b (busy,stall,valid,store,reg,off,last,done)",
                   tag, obs, exp);
        end
    endtask

    initial begin
        start = 0; is_sm_in = 0; mask_in = 0; hold = 0; flush = 0; reset = 1;

        // Reset state
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("reset", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("idle", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);

        // LM 1010_0101: R0,R2,R5,R7
        applyStimulus(1, 0, 8'hA5, 0, 0, 0);
        checkOutput("lm_start", 0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_u0", 1, 1, 1, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_u1", 1, 1, 1, 0, 3'd2, 3'd1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_u2", 1, 1, 1, 0, 3'd5, 3'd2, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_u3", 1, 0, 1, 0, 3'd7, 3'd3, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lm_after", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);

        // SM 0xFF: eight stores R0..R7
        applyStimulus(1, 1, 8'hFF, 0, 0, 0);
        checkOutput("sm_start", 0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0);
            checkOutput($sformatf("sm_u%0d", k), 1, (k != 7), 1, 1, 3'(k), 3'(k), (k == 7), 0);
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("sm_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);

        // Single-bit mask 0x80
        applyStimulus(1, 0, 8'h80, 0, 0, 0);
        checkOutput("one_start", 0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("one_u0", 1, 0, 1, 0, 3'd7, 3'd0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("one_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);

        // Empty mask acts as a NOP
        applyStimulus(1, 1, 8'h00, 0, 0, 0);
        checkOutput("nop_start", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("nop_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("nop_after", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);

        // LM 0x0F with two held cycles on R1
        applyStimulus(1, 0, 8'h0F, 0, 0, 0);
        checkOutput("hold_start", 0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("hold_u0", 1, 1, 1, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("hold_u1a", 1, 1, 1, 0, 3'd1, 3'd1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("hold_u1b", 1, 1, 1, 0, 3'd1, 3'd1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("hold_u1c", 1, 1, 1, 0, 3'd1, 3'd1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("hold_u2", 1, 1, 1, 0, 3'd2, 3'd2, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("hold_u3_held", 1, 1, 1, 0, 3'd3, 3'd3, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("hold_u3", 1, 0, 1, 0, 3'd3, 3'd3, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("hold_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);

        // Flush while R2 of 0x0F is presented
        applyStimulus(1, 0, 8'h0F, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_u1", 1, 1, 1, 0, 3'd1, 3'd1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 1, 0);
        checkOutput("fl_u2", 1, 0, 1, 0, 3'd2, 3'd2, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_idle", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_nodone", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(1, 0, 8'h01, 0, 0, 0);
        checkOutput("fl_restart", 0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_r0", 1, 0, 1, 0, 3'd0, 3'd0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_r0_done", 0, 0, 0, 0, 3'd0, 3'd0, 0, 1);

        // Flush together with start in IDLE discards the start
        applyStimulus(1, 1, 8'h0F, 0, 1, 0);
        checkOutput("fl_start", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("fl_start_idle", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);

        // Reset during the third micro-op of 0xFF
        applyStimulus(1, 1, 8'hFF, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("rst_u2", 1, 1, 1, 1, 3'd2, 3'd2, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_idle", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_nodone", 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for the LM/SM (load/store multiple) instructions of the pipelined IITB-RISC core. It sits beside the ID stage. When decode presents an LM/SM it captures the 8-bit register mask and then issues one single-register load/store micro-op per set mask bit into the ID→RD pipeline register. While it does so it holds fetch and the IF/ID register. The RD/EX stages add `uop_offset` to the base register to form the word address.

## Interface
- `MASK_W`, 8, register-mask width and register count; `uop_reg`/`uop_offset` are log2(MASK_W) = 3 bits.
- `clk` input 1, single clock; all state updates on the posedge.
- `reset` input 1, synchronous, active-high.
- `start` input 1, decode has a valid LM/SM in ID this cycle.
- `is_sm_in` input 1, 1 = SM (store), 0 = LM (load); sampled with `start`.
- `mask_in` input 8, register mask from the instruction; bit i selects Ri; sampled with `start`.
- `hold` input 1, downstream stall from the hazard unit; freezes the sequencer.
- `flush` input 1, branch/jump squash from a later stage; aborts the sequence.
- `busy` output 1, sequencer is in ISSUE.
- `stall_if` output 1, hold PC and the IF/ID register this cycle.
- `uop_valid` output 1, micro-op fields are valid for the ID→RD register.
- `uop_is_store` output 1, micro-op is a store (SM) or a load (LM).
- `uop_reg` output 3, register index to load into or store from.
- `uop_offset` output 3, word offset from the base register (0, 1, 2, …).
- `uop_last` output 1, this micro-op is the final one of the sequence.
- `done` output 1, one-cycle pulse after the sequence completes.

## Operation
- States: IDLE, ISSUE.
- Internal registers: `mask_rem[7:0]`, `cnt[2:0]`, `is_sm`, `done`.
- **IDLE, `start`=1, `flush`=0, `mask_in`≠0:**
  - latch `mask_rem`=`mask_in`, `is_sm`=`is_sm_in`, `cnt`=0.
  - go to ISSUE.
  - `stall_if`=1 this cycle; `uop_valid`=0 (the LM/SM itself becomes a bubble).
- **IDLE, `start`=1, `mask_in`=0:**
  - no micro-ops, no stall; the instruction behaves as a NOP.
  - `done`=1 the next cycle.
- **ISSUE, combinational outputs (decoded from internal registers only):**
  - `uop_valid`=1, `uop_is_store`=`is_sm`, `uop_offset`=`cnt`.
  - `uop_reg` = index of the lowest set bit of `mask_rem` (ascending, R0 first).
  - `uop_last` = exactly one bit set in `mask_rem`.
  - `busy`=1; `stall_if` = ~`uop_last` | `hold`.
- **ISSUE, `hold`=0, at the clock edge:**
  - clear the issued bit in `mask_rem`; `cnt` += 1.
  - if `uop_last`: go to IDLE and set `done`=1 for the next cycle.
- **ISSUE, `hold`=1:** all state and outputs are frozen; the same micro-op is re-presented.
- **`flush`=1, any state:**
  - next state IDLE, `mask_rem`=0, `cnt`=0, no `done`.
  - a simultaneous `start` is ignored.
  - `stall_if` is forced 0 in that cycle.
- **Priority:** `reset` > `flush` > `hold` > normal advance.
- **`start` in ISSUE:** ignored. It cannot legally occur because fetch is stalled.
- **`cnt`** never wraps within a sequence: at most 8 micro-ops, so it reaches at most 7.

## Timing
- **Reset values:**
  - state IDLE; `mask_rem`=0, `cnt`=0, `is_sm`=0.
  - outputs `busy`, `stall_if`, `uop_valid`, `uop_is_store`, `uop_last`, `done` = 0; `uop_reg`=0, `uop_offset`=0.
- **Reset mid-sequence:** next cycle is IDLE with all outputs at reset values; no `done`.
- **Latency:**
  - `start` at cycle T → first micro-op valid at T+1.
  - N micro-ops occupy T+1..T+N (no holds).
  - `done` at T+N+1.
- **`stall_if` high cycles:** T..T+N−1; fetch resumes at T+N. Each held cycle extends all of these by one.
- **Combinational paths:** `stall_if` depends combinationally on `start`, `mask_in` (IDLE), `hold` and `flush`. All `uop_*` outputs depend on registers only.

## Test plan
- **LM, `mask_in`=8'b1010_0101 at T:**
  - T+1..T+4 give `uop_reg`=0,2,5,7 with `uop_offset`=0,1,2,3, `uop_is_store`=0.
  - `uop_last` only at T+4; `stall_if` high T..T+3; `done` at T+5.
- **SM, `mask_in`=8'hFF:**
  - 8 micro-ops, R0..R7, offsets 0..7, `uop_is_store`=1.
  - `uop_last` on the 8th; `done` one cycle later.
- **`mask_in`=8'h80:** one micro-op (R7, offset 0, `uop_last`=1); `stall_if` only in the start cycle. **`mask_in`=0:** `uop_valid` never asserted, `stall_if`=0, `done` at T+1.
- **LM, `mask_in`=8'h0F, `hold` high for 2 cycles while R1 is presented:**
  - R1/offset 1 is held for 3 cycles with `stall_if`=1.
  - then R2, R3 follow; `done` is delayed by 2 cycles.
- **`flush` while R2 of `mask_in`=8'h0F is presented:** next cycle IDLE, `uop_valid`=0, `stall_if`=0, no `done`. A subsequent `start` with `mask_in`=8'h01 issues R0 at offset 0.
- **`reset` during the 3rd micro-op of `mask_in`=8'hFF:** next cycle all outputs are at reset values and `busy`=0.
